// File: rtl/conv_window_3x3_pkg.sv
// conv_window_3x3_pkg: shared constants, pixel type and tap index helper
package conv_window_3x3_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W = 80;
    localparam int DEF_IMG_H = 80;
    typedef logic [DEF_DATA_W-1:0] pixel_t;
    function automatic int tap(input int i, input int j);
        return 3 * i + j;
    endfunction
endpackage

// File: rtl/conv_window_3x3_line_buffer.sv
// conv_window_3x3_line_buffer: one image row of pixels, async read, sync write
module conv_window_3x3_line_buffer #(
    parameter int DEPTH = 80,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic hit;
    assign hit = 32'(addr) < DEPTH;
    assign rdata = hit ? mem[addr] : '0;
    always_ff @(posedge clk) begin
        if (we && hit) mem[addr] <= wdata;
    end
endmodule

// File: rtl/conv_window_3x3.sv
// conv_window_3x3: raster stream to 3x3 valid-convolution windows using two line buffers
module conv_window_3x3
    import conv_window_3x3_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int COL_W = 7,
    parameter int ROW_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [COL_W-1:0]  col_in,
    output logic              win_valid,
    output logic [9*DATA_W-1:0] win_data,
    output logic [ROW_W-1:0]  win_row,
    output logic [COL_W-1:0]  win_col,
    output logic              frame_done,
    output logic              col_err
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    logic [DATA_W-1:0] win [3][3];
    logic [DATA_W-1:0] lba_q, lbb_q;
    logic [COL_W-1:0] exp_col;
    logic [ROW_W-1:0] row;
    logic emit, we;
    assign we = in_valid && reset;
    assign emit = in_valid && row >= ROW_W'(2) && exp_col >= COL_W'(2);
    conv_window_3x3_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb_a (
        .clk(clk), .we(we), .addr(col_in), .wdata(in_data), .rdata(lba_q)
    );
    conv_window_3x3_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb_b (
        .clk(clk), .we(we), .addr(col_in), .wdata(lba_q), .rdata(lbb_q)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_valid <= 1'b0;
            frame_done <= 1'b0;
            col_err <= 1'b0;
            win_row <= '0;
            win_col <= '0;
            row <= '0;
            exp_col <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
        end else begin
            win_valid <= emit;
            frame_done <= emit && row == ROW_LAST && exp_col == COL_LAST;
            if (in_valid) begin
                col_err <= col_err | (col_in != exp_col);
                exp_col <= exp_col == COL_LAST ? '0 : exp_col + 1'b1;
                if (exp_col == COL_LAST) row <= row == ROW_LAST ? '0 : row + 1'b1;
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lbb_q;
                win[1][2] <= lba_q;
                win[2][2] <= in_data;
                if (emit) begin
                    win_row <= row - ROW_W'(2);
                    win_col <= exp_col - COL_W'(2);
                end
            end
        end
    end
    always_comb begin
        win_data = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                win_data[tap(i, j)*DATA_W +: DATA_W] = win[i][j];
    end
endmodule

// File: tb/tb_conv_window_3x3.sv
// tb_conv_window_3x3: directed ramp/fill/gap/error/reset frames checked against a pixel model
module tb_conv_window_3x3;
    import conv_window_3x3_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [6:0] col_in = '0;
    logic win_valid, frame_done, col_err;
    logic [71:0] win_data;
    logic [6:0] win_row, win_col;
    int checks = 0;
    int errors = 0;
    int windows = 0;
    int dones = 0;
    conv_window_3x3 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .col_in(col_in),
        .win_valid(win_valid), .win_data(win_data), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done), .col_err(col_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask
    task automatic cyc(input logic rs, input logic v, input logic [7:0] d, input logic [6:0] c);
        reset = rs;
        in_valid = v;
        in_data = d;
        col_in = c;
        @(posedge clk);
        #1;
    endtask
    function automatic pixel_t pix(input int mode, input int fill, input int r, input int c);
        return mode == 0 ? pixel_t'((r * 80 + c) & 255) : pixel_t'(fill);
    endfunction
    function automatic logic [71:0] exp_win(input int mode, input int fill, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[tap(i, j)*8 +: 8] = pix(mode, fill, r + i, c + j);
        return w;
    endfunction
    task automatic run(input int mode, input int fill, input int gap, input int p0, input int p1);
        for (int p = p0; p < p1; p++) begin
            int r, c;
            r = p / 80;
            c = p % 80;
            while (gap > 0 && int'($urandom_range(99)) < gap) begin
                cyc(1'b1, 1'b0, 8'($urandom), 7'(c));
                chk("idle_valid", win_valid, 0);
            end
            cyc(1'b1, 1'b1, pix(mode, fill, r, c), 7'(c));
            if (r >= 2 && c >= 2) begin
                chk("win_valid", win_valid, 1);
                chk("win_row", win_row, r - 2);
                chk("win_col", win_col, c - 2);
                chk("win_data", win_data, exp_win(mode, fill, r - 2, c - 2));
                chk("frame_done", frame_done, (r == 79 && c == 79) ? 1 : 0);
                windows++;
                if (frame_done) dones++;
            end else begin
                chk("no_win", win_valid, 0);
            end
        end
    endtask
    initial begin
        cyc(1'b0, 1'b1, 8'h55, 7'd0);
        cyc(1'b0, 1'b1, 8'h66, 7'd1);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_data", win_data, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_col_err", col_err, 0);
        run(0, 0, 0, 0, 163);
        chk("first_tap0", win_data[7:0], 0);
        chk("first_tap4", win_data[39:32], 81);
        chk("first_tap8", win_data[71:64], 162);
        run(0, 0, 0, 163, 6400);
        chk("ramp_windows", windows, 6084);
        chk("ramp_dones", dones, 1);
        cyc(1'b1, 1'b0, 8'h00, 7'd0);
        chk("post_frame_valid", win_valid, 0);
        chk("post_frame_done", frame_done, 0);
        windows = 0;
        dones = 0;
        run(0, 0, 40, 0, 6400);
        chk("gap_windows", windows, 6084);
        chk("gap_dones", dones, 1);
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 8'h00, 7'(c));
        chk("col_err_clean", col_err, 0);
        cyc(1'b1, 1'b1, 8'h00, 7'd5);
        chk("col_err_set", col_err, 1);
        for (int p = 5; p < 160; p++) cyc(1'b1, 1'b1, 8'h00, 7'(p % 80));
        chk("col_err_held", col_err, 1);
        cyc(1'b0, 1'b0, 8'h00, 7'd0);
        chk("col_err_cleared", col_err, 0);
        run(0, 0, 0, 0, 3210);
        cyc(1'b0, 1'b1, 8'hAA, 7'd10);
        chk("midrst_valid", win_valid, 0);
        chk("midrst_data", win_data, 0);
        chk("midrst_row", win_row, 0);
        windows = 0;
        dones = 0;
        run(0, 0, 0, 0, 6400);
        chk("restart_windows", windows, 6084);
        chk("restart_dones", dones, 1);
        windows = 0;
        dones = 0;
        run(1, 8'h11, 0, 0, 6400);
        run(1, 8'h22, 0, 0, 6400);
        chk("fill_windows", windows, 12168);
        chk("fill_dones", dones, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
